// File: rtl/stack_player.sv
// rtl/stack_player.sv - drains a pop-only stack into a paced DAC sample stream
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   start           begin draining (honoured in IDLE only)
//   abort           return to IDLE on the next edge, no done pulse
//   period [15:0]   clk cycles per output sample (0 behaves as 1)
//   stack_data      stack read data, valid the cycle after a pop
//   stack_empty     stack empty flag
//   stack_enable    stack enable strobe (registered)
//   stack_operation stack operation, always 0 (pop)
//   sample_out      current waveform sample (registered)
//   sample_valid    one-cycle pulse when sample_out updates
//   busy            high whenever not IDLE
//   done            one-cycle pulse after normal completion
//
// Build option: PLAYER_HOLD_LAST_EN keeps the last sample on sample_out while
// idle; otherwise sample_out returns to 0x0000 on the edge entering IDLE.
module stack_player (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] period,
   input  logic [15:0] stack_data,
   input  logic        stack_empty,
   output logic        stack_enable,
   output logic        stack_operation,
   output logic [15:0] sample_out,
   output logic        sample_valid,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      POP   = 3'd1,
      LATCH = 3'd2,
      HOLD  = 3'd3,
      FIN   = 3'd4
   } state_t;

   state_t      state;
   logic [15:0] counter;
   logic [15:0] idle_sample;

   // Value sample_out takes on the edge that enters IDLE.
`ifdef PLAYER_HOLD_LAST_EN
   assign idle_sample = sample_out;
`else
   assign idle_sample = 16'h0000;
`endif

   assign stack_operation = 1'b0;
   assign busy            = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         counter      <= 16'h0000;
         sample_out   <= 16'h0000;
         sample_valid <= 1'b0;
         stack_enable <= 1'b0;
         done         <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         stack_enable <= 1'b0;
         done         <= 1'b0;
         if ((state != IDLE) && abort) begin
            // A pop already strobed in POP still happens; its word is never latched.
            state      <= IDLE;
            sample_out <= idle_sample;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (stack_empty) begin
                        state <= FIN;
                     end else begin
                        state        <= POP;
                        stack_enable <= 1'b1;
                     end
                  end
               end
               POP: begin
                  state <= LATCH;
               end
               LATCH: begin
                  sample_out   <= stack_data;
                  sample_valid <= 1'b1;
                  // HOLD lasts max(period,1) cycles; with POP and LATCH the
                  // spacing between samples is max(period,1)+2.
                  counter      <= (period == 16'h0000) ? 16'h0000 : period - 16'h0001;
                  state        <= HOLD;
               end
               HOLD: begin
                  if (counter == 16'h0000) begin
                     if (stack_empty) begin
                        state <= FIN;
                     end else begin
                        state        <= POP;
                        stack_enable <= 1'b1;
                     end
                  end else begin
                     counter <= counter - 16'h0001;
                  end
               end
               FIN: begin
                  done       <= 1'b1;
                  state      <= IDLE;
                  sample_out <= idle_sample;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stack_player.sv
// tb/tb_stack_player.sv - directed scoreboard bench for stack_player
module tb_stack_player;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] period;
   logic [15:0] stack_data;
   logic        stack_empty;
   logic        stack_enable;
   logic        stack_operation;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic        busy;
   logic        done;

   stack_player dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .abort           (abort),
      .period          (period),
      .stack_data      (stack_data),
      .stack_empty     (stack_empty),
      .stack_enable    (stack_enable),
      .stack_operation (stack_operation),
      .sample_out      (sample_out),
      .sample_valid    (sample_valid),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;
   int cyc;
   int pops;
   int sv_cnt;
   int done_cnt;
   int done_cyc;
   int last_sv;
   int exp_gap;
   int start_cyc;
   logic [15:0] stk[$];
   logic [15:0] exp_q[$];
   logic [15:0] idle_exp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: stack model reacts to the strobe seen before the edge, then
   // outputs are observed 1 time unit after the edge.
   task automatic tick();
      logic en;
      en = stack_enable;
      @(posedge clk);
      #1;
      cyc++;
      if (en) begin
         chk("pop_nonempty", 32'(stk.size() > 0), 32'd1);
         if (stk.size() > 0) stack_data = stk.pop_front();
         pops++;
      end
      stack_empty = (stk.size() == 0);
      if (sample_valid) begin
         chk("exp_avail", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) chk("sample", 32'(sample_out), 32'(exp_q.pop_front()));
         if (last_sv >= 0) chk("gap", 32'(cyc - last_sv), 32'(exp_gap));
         last_sv = cyc;
         sv_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   endtask

   task automatic clear_counts();
      pops     = 0;
      sv_cnt   = 0;
      done_cnt = 0;
      done_cyc = -1;
      last_sv  = -1;
   endtask

   task automatic load(input logic [15:0] w, input bit expect_play);
      stk.push_back(w);
      if (expect_play) exp_q.push_back(w);
      stack_empty = 1'b0;
   endtask

   task automatic pulse_start();
      start_cyc = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_to_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(n < 200), 32'd1);
      repeat (3) tick();
   endtask

   task automatic wait_samples(input int k);
      int n;
      n = 0;
      while (sv_cnt < k && n < 200) begin
         tick();
         n++;
      end
      chk("sample_timeout", 32'(n < 200), 32'd1);
   endtask

   initial begin
      total = 0;
      bad = 0;
      cyc = 0;
      start_cyc = 0;
      exp_gap = 0;
      clear_counts();
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      period = 16'd4;
      stack_data = 16'h0000;
      stack_empty = 1'b1;

      // Reset state
      repeat (2) tick();
      rst = 1'b0;
      chk("rst_sample_out", 32'(sample_out), 32'h0);
      chk("rst_sample_valid", 32'(sample_valid), 32'd0);
      chk("rst_stack_enable", 32'(stack_enable), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_stack_op", 32'(stack_operation), 32'd0);

      // Three entries, period 4: spacing 6
      clear_counts();
      exp_gap = 6;
      load(16'h1111, 1'b1);
      load(16'h2222, 1'b1);
      load(16'h3333, 1'b1);
      period = 16'd4;
      pulse_start();
      chk("busy_after_start", 32'(busy), 32'd1);
      run_to_idle();
      chk("t1_samples", 32'(sv_cnt), 32'd3);
      chk("t1_pops", 32'(pops), 32'd3);
      chk("t1_done", 32'(done_cnt), 32'd1);
      chk("t1_exp_left", 32'(exp_q.size()), 32'd0);
      chk("t1_stack_op", 32'(stack_operation), 32'd0);
`ifdef PLAYER_HOLD_LAST_EN
      idle_exp = 16'h3333;
`else
      idle_exp = 16'h0000;
`endif
      chk("t1_idle_out", 32'(sample_out), 32'(idle_exp));

      // Empty stack: no pop, done two cycles after start
      clear_counts();
      pulse_start();
      run_to_idle();
      chk("t2_pops", 32'(pops), 32'd0);
      chk("t2_done", 32'(done_cnt), 32'd1);
      chk("t2_done_lat", 32'(done_cyc - start_cyc), 32'd2);
      chk("t2_samples", 32'(sv_cnt), 32'd0);
      chk("t2_idle_out", 32'(sample_out), 32'(idle_exp));

      // period 0 behaves as 1: spacing 3
      clear_counts();
      exp_gap = 3;
      period = 16'd0;
      load(16'hA5A5, 1'b1);
      load(16'h5A5A, 1'b1);
      pulse_start();
      run_to_idle();
      chk("t3_samples", 32'(sv_cnt), 32'd2);
      chk("t3_pops", 32'(pops), 32'd2);
      chk("t3_done", 32'(done_cnt), 32'd1);

      // Abort one cycle after the second sample, four entries
      clear_counts();
      exp_gap = 6;
      period = 16'd4;
      load(16'h0101, 1'b1);
      load(16'h0202, 1'b1);
      load(16'h0303, 1'b0);
      load(16'h0404, 1'b0);
      pulse_start();
      wait_samples(2);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_busy", 32'(busy), 32'd0);
      repeat (4) tick();
      chk("t4_done", 32'(done_cnt), 32'd0);
      chk("t4_pops", 32'(pops), 32'd2);
      chk("t4_stack_en", 32'(stack_enable), 32'd0);
`ifdef PLAYER_HOLD_LAST_EN
      chk("t4_idle_out", 32'(sample_out), 32'h0202);
`else
      chk("t4_idle_out", 32'(sample_out), 32'h0000);
`endif
      stk.delete();
      stack_empty = 1'b1;

      // Reset in HOLD, start while busy ignored
      clear_counts();
      load(16'h7777, 1'b1);
      load(16'h8888, 1'b0);
      load(16'h9999, 1'b0);
      pulse_start();
      wait_samples(1);
      start = 1'b1;
      tick();
      start = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_sample_out", 32'(sample_out), 32'h0);
      chk("t5_sample_valid", 32'(sample_valid), 32'd0);
      chk("t5_stack_enable", 32'(stack_enable), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      repeat (4) tick();
      chk("t5_pops", 32'(pops), 32'd1);
      chk("t5_done_cnt", 32'(done_cnt), 32'd0);
      chk("t5_exp_left", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
